// File: rtl/cs_split_ctrl.sv
// Clip-and-split controller wrapped around cs_stack.
// Takes one triangle at a time and culls it when it lies fully off-screen.
// Otherwise it midpoint-subdivides the triangle depth-first until its bbox fits MAX_EXT.
// Pending pieces are parked in cs_stack; finished pieces go to raster setup.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for an input triangle (in_ready=1)
// CLASSIFY  | bbox of cur: cull, emit as-is, or split
// PUSH0..2  | push sub-triangles s0, s1, s2 one per cycle; s3 becomes cur
// EMIT      | hold cur on out_tri until out_ready
// NEXT      | stack empty -> done pulse, else stk_pop issued this cycle
// POPWAIT   | registered stack data arrives, load into cur
module cs_split_ctrl #(
  parameter int COORD_W  = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int MAX_EXT  = 32,
  parameter int DEPTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [9*COORD_W-1:0] in_tri,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [9*COORD_W-1:0] out_tri,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [9*COORD_W-1:0] stk_wr_tri,
  input  logic [9*COORD_W-1:0] stk_rd_tri,
  output logic                 busy,
  output logic                 done
);

  localparam int VW = 3*COORD_W;
  localparam int OW = $clog2(DEPTH+1);
  localparam logic signed [COORD_W:0] EXT_S = (COORD_W+1)'(MAX_EXT);
  localparam logic signed [COORD_W:0] SW_S  = (COORD_W+1)'(SCREEN_W);
  localparam logic signed [COORD_W:0] SH_S  = (COORD_W+1)'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_PUSH0, S_PUSH1, S_PUSH2, S_EMIT, S_NEXT, S_POPWAIT
  } state_t;

  state_t              state;
  logic [OW-1:0]       occ;
  logic [9*COORD_W-1:0] cur;
  logic [VW-1:0]       m01, m12, m20;

  // Floor midpoint: one extra bit so the sum never overflows, then drop the LSB.
  function automatic logic [COORD_W-1:0] mid_c(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b);
    logic signed [COORD_W:0] s;
    s = $signed({a[COORD_W-1], a}) + $signed({b[COORD_W-1], b});
    return s[COORD_W:1];
  endfunction

  function automatic logic [VW-1:0] mid_v(input logic [VW-1:0] a, input logic [VW-1:0] b);
    return {mid_c(a[3*COORD_W-1:2*COORD_W], b[3*COORD_W-1:2*COORD_W]),
            mid_c(a[2*COORD_W-1:COORD_W],   b[2*COORD_W-1:COORD_W]),
            mid_c(a[COORD_W-1:0],           b[COORD_W-1:0])};
  endfunction

  logic [VW-1:0] v0, v1, v2, m01_c, m12_c, m20_c;
  logic signed [COORD_W:0] x0, x1, x2, y0, y1, y2;
  logic signed [COORD_W:0] minx, maxx, miny, maxy;
  logic cull, fits, no_room;

  assign v0 = cur[VW-1:0];
  assign v1 = cur[2*VW-1:VW];
  assign v2 = cur[3*VW-1:2*VW];
  assign m01_c = mid_v(v0, v1);
  assign m12_c = mid_v(v1, v2);
  assign m20_c = mid_v(v2, v0);

  assign x0 = {v0[COORD_W-1], v0[COORD_W-1:0]};
  assign x1 = {v1[COORD_W-1], v1[COORD_W-1:0]};
  assign x2 = {v2[COORD_W-1], v2[COORD_W-1:0]};
  assign y0 = {v0[2*COORD_W-1], v0[2*COORD_W-1:COORD_W]};
  assign y1 = {v1[2*COORD_W-1], v1[2*COORD_W-1:COORD_W]};
  assign y2 = {v2[2*COORD_W-1], v2[2*COORD_W-1:COORD_W]};

  // Screen-space bounding box of the current triangle.
  always_comb begin
    minx = x0; maxx = x0; miny = y0; maxy = y0;
    if (x1 < minx) minx = x1;
    if (x2 < minx) minx = x2;
    if (x1 > maxx) maxx = x1;
    if (x2 > maxx) maxx = x2;
    if (y1 < miny) miny = y1;
    if (y2 < miny) miny = y2;
    if (y1 > maxy) maxy = y1;
    if (y2 > maxy) maxy = y2;
  end

  // Extents use the widened range so max-min cannot wrap.
  assign cull    = (maxx < 0) || (maxy < 0) || (minx >= SW_S) || (miny >= SH_S);
  assign fits    = ((maxx - minx) <= EXT_S) && ((maxy - miny) <= EXT_S);
  // A split needs three free slots; with fewer the piece is emitted oversized.
  assign no_room = int'(occ) > DEPTH - 3;

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      occ        <= '0;
      cur        <= '0;
      m01        <= '0;
      m12        <= '0;
      m20        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_tri    <= '0;
      stk_push   <= 1'b0;
      stk_pop    <= 1'b0;
      stk_wr_tri <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cur      <= in_tri;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          if (cull) begin
            state <= S_NEXT;
            if (occ == '0) done <= 1'b1;
            else           stk_pop <= 1'b1;
          end else if (fits || no_room) begin
            out_valid <= 1'b1;
            out_tri   <= cur;
            state     <= S_EMIT;
          end else begin
            m01        <= m01_c;
            m12        <= m12_c;
            m20        <= m20_c;
            stk_push   <= 1'b1;
            stk_wr_tri <= {m20_c, m01_c, v0};
            state      <= S_PUSH0;
          end
        end
        S_PUSH0: begin
          occ        <= occ + 1'b1;
          stk_push   <= 1'b1;
          stk_wr_tri <= {m12, v1, m01};
          state      <= S_PUSH1;
        end
        S_PUSH1: begin
          occ        <= occ + 1'b1;
          stk_push   <= 1'b1;
          stk_wr_tri <= {v2, m12, m20};
          state      <= S_PUSH2;
        end
        S_PUSH2: begin
          occ   <= occ + 1'b1;
          cur   <= {m20, m12, m01};
          state <= S_CLASSIFY;
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_NEXT;
            if (occ == '0) done <= 1'b1;
            else           stk_pop <= 1'b1;
          end
        end
        S_NEXT: begin
          if (occ == '0) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            occ   <= occ - 1'b1;
            state <= S_POPWAIT;
          end
        end
        S_POPWAIT: begin
          cur   <= stk_rd_tri;
          state <= S_CLASSIFY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_split_ctrl.sv
// Directed bench for cs_split_ctrl with a behavioural cs_stack (depth 8, registered read).
module tb_cs_split_ctrl;

  typedef logic [143:0] w_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic stk_push, stk_pop, busy, done;
  w_t   in_tri, out_tri, stk_wr_tri;
  w_t   stk_rd_tri = '0;

  cs_split_ctrl #(.COORD_W(16), .SCREEN_W(640), .SCREEN_H(480), .MAX_EXT(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tri(in_tri),
    .out_valid(out_valid), .out_ready(out_ready), .out_tri(out_tri),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wr_tri(stk_wr_tri), .stk_rd_tri(stk_rd_tri),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Stack model: flags simultaneous push/pop, overflow and underflow.
  w_t smem [0:7];
  int sdepth = 0;
  int n_push = 0;
  int n_pop  = 0;
  bit s_err  = 1'b0;
  always @(posedge clk) begin
    if (rst) sdepth = 0;
    else begin
      if (stk_push && stk_pop) s_err = 1'b1;
      if (stk_push) begin
        n_push++;
        if (sdepth >= 8) s_err = 1'b1;
        else begin smem[sdepth] = stk_wr_tri; sdepth++; end
      end
      if (stk_pop) begin
        n_pop++;
        if (sdepth == 0) s_err = 1'b1;
        else begin sdepth--; stk_rd_tri <= smem[sdepth]; end
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  w_t got_q[$];

  task automatic check(input string tag, input w_t got, input w_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic w_t mk(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy);
    return {16'd0, 16'(cy), 16'(cx), 16'd0, 16'(by), 16'(bx), 16'd0, 16'(ay), 16'(ax)};
  endfunction

  // Presents a triangle in IDLE; returns at the negedge inside CLASSIFY.
  task automatic send(input w_t t);
    check("accept_ready", w_t'(in_ready), w_t'(1));
    in_valid = 1'b1;
    in_tri   = t;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Collects outputs until done, stalling out_ready `stall` cycles per output.
  task automatic drain(input int stall, input int limit, output bit saw_done, output int peak);
    w_t held;
    int w;
    saw_done  = 1'b0;
    peak      = sdepth;
    w         = 0;
    held      = '0;
    out_ready = (stall == 0);
    for (int c = 0; c < limit; c++) begin
      if (sdepth > peak) peak = sdepth;
      if (done) begin saw_done = 1'b1; break; end
      if (out_valid) begin
        if (w == 0) held = out_tri;
        else check("stall_hold", out_tri, held);
        if (w == stall) begin
          got_q.push_back(out_tri);
          out_ready = 1'b1;
          w = 0;
        end else begin
          out_ready = 1'b0;
          w++;
        end
      end else out_ready = (stall == 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  w_t exp3 [4];

  initial begin
    bit sd;
    int pk, p0, q0, k;
    w_t t1, t2, t3, t5;

    rst = 1'b1; in_valid = 1'b0; in_tri = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  w_t'(in_ready),  w_t'(1));
    check("rst_out_valid", w_t'(out_valid), w_t'(0));
    check("rst_busy",      w_t'(busy),      w_t'(0));
    check("rst_done",      w_t'(done),      w_t'(0));
    check("rst_push_pop",  w_t'({stk_push, stk_pop}), w_t'(0));
    check("rst_out_tri",   out_tri, w_t'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1: bbox extent exactly MAX_EXT, passes through unsplit with 2-cycle latency.
    t1 = mk(10, 10, 18, 10, 10, 18);
    got_q.delete();
    send(t1);
    check("t1_cls_valid", w_t'(out_valid), w_t'(0));
    check("t1_cls_busy",  w_t'(busy),      w_t'(1));
    check("t1_cls_ready", w_t'(in_ready),  w_t'(0));
    @(negedge clk);
    check("t1_lat_valid", w_t'(out_valid), w_t'(1));
    check("t1_lat_tri",   out_tri, t1);
    drain(0, 100, sd, pk);
    check("t1_done",  w_t'(sd), w_t'(1));
    check("t1_count", w_t'(got_q.size()), w_t'(1));
    if (got_q.size() > 0) check("t1_tri", got_q[0], t1);
    @(negedge clk);
    check("t1_idle", w_t'(in_ready), w_t'(1));
    check("t1_done_pulse", w_t'(done), w_t'(0));

    // 2: fully off-screen triangle is culled.
    t2 = mk(-50, -50, -10, -50, -50, -10);
    p0 = n_push;
    send(t2);
    check("t2_cls_done", w_t'(done), w_t'(0));
    @(negedge clk);
    check("t2_done",     w_t'(done),      w_t'(1));
    check("t2_no_out",   w_t'(out_valid), w_t'(0));
    check("t2_occ",      w_t'(sdepth),    w_t'(0));
    check("t2_no_push",  w_t'(n_push - p0), w_t'(0));
    @(negedge clk);
    check("t2_idle", w_t'(in_ready), w_t'(1));

    // 3: one split, outputs in LIFO order.
    t3 = mk(0, 0, 16, 0, 0, 16);
    exp3[0] = mk(8, 0, 8, 8, 0, 8);
    exp3[1] = mk(0, 8, 8, 8, 0, 16);
    exp3[2] = mk(8, 0, 16, 0, 8, 8);
    exp3[3] = mk(0, 0, 8, 0, 0, 8);
    for (int st = 0; st <= 5; st += 5) begin
      got_q.delete();
      p0 = n_push; q0 = n_pop;
      send(t3);
      drain(st, 500, sd, pk);
      check($sformatf("t3_s%0d_done", st),  w_t'(sd), w_t'(1));
      check($sformatf("t3_s%0d_count", st), w_t'(got_q.size()), w_t'(4));
      for (int i = 0; i < 4; i++)
        if (i < got_q.size()) check($sformatf("t3_s%0d_out%0d", st, i), got_q[i], exp3[i]);
      check($sformatf("t3_s%0d_push", st), w_t'(n_push - p0), w_t'(3));
      check($sformatf("t3_s%0d_pop", st),  w_t'(n_pop - q0),  w_t'(3));
      @(negedge clk);
    end

    // 5: large triangle, tiny extents; stack fills to exactly DEPTH and no further.
    t5 = mk(0, 0, 400, 0, 0, 400);
    got_q.delete();
    p0 = n_push; q0 = n_pop;
    send(t5);
    drain(0, 40000, sd, pk);
    check("t5_done",   w_t'(sd),    w_t'(1));
    check("t5_peak",   w_t'(pk),    w_t'(8));
    check("t5_stk_ok", w_t'(s_err), w_t'(0));
    check("t5_empty",  w_t'(sdepth), w_t'(0));
    check("t5_balance", w_t'(n_push - p0), w_t'(n_pop - q0));
    check("t5_has_out", w_t'(got_q.size() > 3), w_t'(1));
    @(negedge clk);

    // 6: reset during PUSH1 (second push cycle).
    send(t3);
    k = 0;
    for (int c = 0; c < 20; c++) begin
      if (stk_push) k++;
      if (k == 2) break;
      @(negedge clk);
    end
    check("t6_reach_push1", w_t'(k), w_t'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_in_ready",  w_t'(in_ready),  w_t'(1));
    check("t6_push_pop",  w_t'({stk_push, stk_pop}), w_t'(0));
    check("t6_out_valid", w_t'(out_valid), w_t'(0));
    check("t6_busy_done", w_t'({busy, done}), w_t'(0));
    check("t6_out_tri",   out_tri, w_t'(0));
    @(negedge clk);
    check("t6_still_idle", w_t'({in_ready, stk_push, stk_pop, busy}), w_t'(4'b1000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
